// File: rtl/mux16_rr_sched_if.sv
// Bundle for the 16-requester round-robin mux scheduler: requester side
// (req/data/ack) plus the downstream valid/ready channel and mux select.
interface mux16_rr_sched_if;
    logic [15:0] req;
    logic [15:0] data;
    logic [15:0] ack;
    logic [3:0]  select;
    logic        out_valid;
    logic        out_data;
    logic        out_ready;

    // master: requesters and consumer; slave: the scheduler itself
    modport master (
        output req,
        output data,
        output out_ready,
        input  ack,
        input  select,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  req,
        input  data,
        input  out_ready,
        output ack,
        output select,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/mux16_rr_sched.sv
// Round-robin scheduler sharing one 16:1 single-bit mux between 16 requesters,
// with up to BURST transfers per grant over a valid/ready handshake.

module mux_16 (
    input  logic [15:0] d,
    input  logic [3:0]  sel,
    output logic        y
);
    assign y = d[sel];
endmodule

module mux16_rr_sched #(
    parameter int unsigned BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    mux16_rr_sched_if.slave  bus
);
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic [4:0] BURST_W = 5'(BURST);

    state_t      state_reg, state_next;
    logic [3:0]  ptr_reg, ptr_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic [3:0]  select_reg, select_next;

    logic [31:0] req_dbl;
    logic [15:0] req_rot;
    logic [3:0]  found_idx;
    logic [3:0]  winner;
    logic [4:0]  cnt_inc;
    logic        out_valid;
    logic        fire;
    logic        req_sel;

    // Rotate so bit 0 of req_rot is channel ptr; lowest set bit wins.
    assign req_dbl = {bus.req, bus.req} >> ptr_reg;
    assign req_rot = req_dbl[15:0];

    always_comb begin
        found_idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (req_rot[i]) begin
                found_idx = 4'(i);
            end
        end
    end

    assign winner    = ptr_reg + found_idx;
    assign out_valid = (state_reg == ST_GRANT);
    assign fire      = out_valid & bus.out_ready;
    assign req_sel   = bus.req[select_reg];
    assign cnt_inc   = {1'b0, cnt_reg} + 5'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= ST_IDLE;
            ptr_reg    <= 4'd0;
            cnt_reg    <= 4'd0;
            select_reg <= 4'd0;
        end else begin
            state_reg  <= state_next;
            ptr_reg    <= ptr_next;
            cnt_reg    <= cnt_next;
            select_reg <= select_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        ptr_next    = ptr_reg;
        cnt_next    = cnt_reg;
        select_next = select_reg;
        case (state_reg)
            ST_IDLE: begin
                if (|bus.req) begin
                    select_next = winner;
                    cnt_next    = 4'd0;
                    state_next  = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (fire) begin
                    cnt_next = cnt_inc[3:0];
                    if (!((cnt_inc < BURST_W) && req_sel)) begin
                        state_next = ST_IDLE;
                        ptr_next   = select_reg + 4'd1;
                    end
                end else if (!req_sel) begin
                    // Requester withdrew before its transfer: release without ack.
                    state_next = ST_IDLE;
                    ptr_next   = select_reg + 4'd1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_ack
            assign bus.ack[gi] = fire && (select_reg == 4'(gi));
        end
    endgenerate

    assign bus.select    = select_reg;
    assign bus.out_valid = out_valid;

    mux_16 u_mux (
        .d   (bus.data),
        .sel (select_reg),
        .y   (bus.out_data)
    );
endmodule

// File: tb/tb_mux16_rr_sched.sv
// Directed bench for mux16_rr_sched: one BURST=4 and one BURST=1 instance,
// hand-computed expectations, one line per failed comparison plus a summary.
module tb_mux16_rr_sched;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    mux16_rr_sched_if bus4();
    mux16_rr_sched_if bus1();

    mux16_rr_sched #(.BURST(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
    mux16_rr_sched #(.BURST(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // status word: {out_valid, select, ack}
    logic [20:0] got;
    logic [20:0] want;

    task automatic test_reset();
        @(negedge clk);
        bus4.req = 16'h0080; bus4.data = 16'h0001; bus4.out_ready = 1'b0;
        #1;
        got = {bus4.out_valid, bus4.select, bus4.ack}; want = {1'b0, 4'd0, 16'h0000};
        n_cmp++; if (got !== want) begin n_bad++; $display("FAIL reset_idle: got %h want %h", got, want); end
        @(negedge clk); #1;
        got = {bus4.out_valid, bus4.select, bus4.ack}; want = {1'b1, 4'd7, 16'h0000};
        n_cmp++; if (got !== want) begin n_bad++; $display("FAIL reset_pre_grant: got %h want %h", got, want); end
        rst = 1'b0;
        bus4.out_ready = 1'b1;
        #1;
        got = {bus4.out_valid, bus4.select, bus4.ack}; want = {1'b1 ^ 1'b1, 4'd0, 16'h0000};
        n_cmp++; if (got !== want) begin n_bad++; $display("FAIL reset_async: got %h want %h", got, want); end
        n_cmp++; if (bus4.out_data !== 1'b1) begin n_bad++; $display("FAIL reset_out_data: got %b want 1", bus4.out_data); end
        @(negedge clk);
        bus4.out_ready = 1'b0;
        rst = 1'b1;
        #1;
        n_cmp++; if (bus4.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_release_idle: got %b want 0", bus4.out_valid); end
        @(negedge clk); #1;
        got = {bus4.out_valid, bus4.select, bus4.ack}; want = {1'b1, 4'd7, 16'h0000};
        n_cmp++; if (got !== want) begin n_bad++; $display("FAIL reset_first_grant: got %h want %h", got, want); end
        bus4.req = 16'h0000;
        @(negedge clk); #1;
        n_cmp++; if (bus4.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_cleanup: got %b want 0", bus4.out_valid); end
    endtask

    // ptr is 8 on entry; channel 5 is the only requester.
    task automatic test_burst_limit();
        logic [15:0] pat [4];
        pat[0] = 16'h0020; pat[1] = 16'hFFDF; pat[2] = 16'h0F20; pat[3] = 16'h0000;
        @(negedge clk);
        bus4.req = 16'h0020; bus4.out_ready = 1'b1; bus4.data = 16'h0020;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus4.data = pat[k];
            #1;
            got = {bus4.out_valid, bus4.select, bus4.ack}; want = {1'b1, 4'd5, 16'h0020};
            n_cmp++; if (got !== want) begin n_bad++; $display("FAIL burst_ack[%0d]: got %h want %h", k, got, want); end
            n_cmp++; if (bus4.out_data !== pat[k][5]) begin n_bad++; $display("FAIL burst_data[%0d]: got %b want %b", k, bus4.out_data, pat[k][5]); end
        end
        @(negedge clk); #1;
        got = {bus4.out_valid, bus4.select, bus4.ack}; want = {1'b0, 4'd5, 16'h0000};
        n_cmp++; if (got !== want) begin n_bad++; $display("FAIL burst_bubble: got %h want %h", got, want); end
        @(negedge clk);
        bus4.req = 16'h0000;
        #1;
        got = {bus4.out_valid, bus4.select, bus4.ack}; want = {1'b1, 4'd5, 16'h0020};
        n_cmp++; if (got !== want) begin n_bad++; $display("FAIL burst_regrant_drop: got %h want %h", got, want); end
        @(negedge clk); #1;
        got = {bus4.out_valid, bus4.select, bus4.ack}; want = {1'b0, 4'd5, 16'h0000};
        n_cmp++; if (got !== want) begin n_bad++; $display("FAIL burst_end: got %h want %h", got, want); end
    endtask

    // ptr is 6 on entry; channel 2 wins after wrapping the search.
    task automatic test_backpressure();
        @(negedge clk);
        bus4.req = 16'h0004; bus4.out_ready = 1'b0; bus4.data = 16'h0004;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            got = {bus4.out_valid, bus4.select, bus4.ack}; want = {1'b1, 4'd2, 16'h0000};
            n_cmp++; if (got !== want) begin n_bad++; $display("FAIL bp_hold[%0d]: got %h want %h", k, got, want); end
        end
        @(negedge clk);
        bus4.out_ready = 1'b1; bus4.req = 16'h0000;
        #1;
        got = {bus4.out_valid, bus4.select, bus4.ack}; want = {1'b1, 4'd2, 16'h0004};
        n_cmp++; if (got !== want) begin n_bad++; $display("FAIL bp_ack: got %h want %h", got, want); end
        n_cmp++; if (bus4.out_data !== 1'b1) begin n_bad++; $display("FAIL bp_data: got %b want 1", bus4.out_data); end
        @(negedge clk); #1;
        got = {bus4.out_valid, bus4.select, bus4.ack}; want = {1'b0, 4'd2, 16'h0000};
        n_cmp++; if (got !== want) begin n_bad++; $display("FAIL bp_single: got %h want %h", got, want); end
    endtask

    // ptr is 3 on entry.
    task automatic test_abort();
        @(negedge clk);
        bus4.req = 16'h0200; bus4.out_ready = 1'b0;
        @(negedge clk); #1;
        got = {bus4.out_valid, bus4.select, bus4.ack}; want = {1'b1, 4'd9, 16'h0000};
        n_cmp++; if (got !== want) begin n_bad++; $display("FAIL abort_grant: got %h want %h", got, want); end
        bus4.req = 16'h0000;
        #1;
        n_cmp++; if (bus4.ack !== 16'h0000) begin n_bad++; $display("FAIL abort_no_ack: got %h want 0000", bus4.ack); end
        @(negedge clk); #1;
        got = {bus4.out_valid, bus4.select, bus4.ack}; want = {1'b0, 4'd9, 16'h0000};
        n_cmp++; if (got !== want) begin n_bad++; $display("FAIL abort_idle: got %h want %h", got, want); end
        bus4.req = 16'h1200;
        @(negedge clk); #1;
        got = {bus4.out_valid, bus4.select, bus4.ack}; want = {1'b1, 4'd12, 16'h0000};
        n_cmp++; if (got !== want) begin n_bad++; $display("FAIL abort_next_grant: got %h want %h", got, want); end
        bus4.req = 16'h0000; bus4.out_ready = 1'b1;
        @(negedge clk);
    endtask

    // BURST=1 instance has never been granted, so ptr is 0.
    task automatic test_round_robin();
        logic [3:0]  exp_sel;
        logic [15:0] exp_ack;
        @(negedge clk);
        bus1.req = 16'hFFFF; bus1.out_ready = 1'b1; bus1.data = 16'hA5C3;
        #1;
        n_cmp++; if (bus1.out_valid !== 1'b0) begin n_bad++; $display("FAIL rr_start: got %b want 0", bus1.out_valid); end
        for (int k = 0; k < 33; k++) begin
            @(negedge clk); #1;
            exp_sel = 4'((k / 2) % 16);
            exp_ack = 16'h0001 << exp_sel;
            if (k % 2 == 0) begin
                got = {bus1.out_valid, bus1.select, bus1.ack}; want = {1'b1, exp_sel, exp_ack};
                n_cmp++; if (got !== want) begin n_bad++; $display("FAIL rr_grant[%0d]: got %h want %h", k, got, want); end
                n_cmp++; if (bus1.out_data !== bus1.data[exp_sel]) begin n_bad++; $display("FAIL rr_data[%0d]: got %b want %b", k, bus1.out_data, bus1.data[exp_sel]); end
            end else begin
                got = {bus1.out_valid, bus1.ack}; want = {1'b0, 4'd0, 16'h0000};
                n_cmp++; if (got !== want) begin n_bad++; $display("FAIL rr_bubble[%0d]: got %h want %h", k, got, want); end
            end
        end
        bus1.req = 16'h0000;
    endtask

    // ptr is 1 on entry; grant 14 first so ptr lands on 15.
    task automatic test_wrap_around();
        @(negedge clk);
        bus1.req = 16'h4000; bus1.out_ready = 1'b1;
        @(negedge clk);
        bus1.req = 16'h8008;
        #1;
        got = {bus1.out_valid, bus1.select, bus1.ack}; want = {1'b1, 4'd14, 16'h4000};
        n_cmp++; if (got !== want) begin n_bad++; $display("FAIL wrap_grant14: got %h want %h", got, want); end
        @(negedge clk); #1;
        got = {bus1.out_valid, bus1.select, bus1.ack}; want = {1'b0, 4'd14, 16'h0000};
        n_cmp++; if (got !== want) begin n_bad++; $display("FAIL wrap_bubble0: got %h want %h", got, want); end
        @(negedge clk); #1;
        got = {bus1.out_valid, bus1.select, bus1.ack}; want = {1'b1, 4'd15, 16'h8000};
        n_cmp++; if (got !== want) begin n_bad++; $display("FAIL wrap_grant15: got %h want %h", got, want); end
        @(negedge clk); #1;
        got = {bus1.out_valid, bus1.select, bus1.ack}; want = {1'b0, 4'd15, 16'h0000};
        n_cmp++; if (got !== want) begin n_bad++; $display("FAIL wrap_bubble1: got %h want %h", got, want); end
        @(negedge clk); #1;
        got = {bus1.out_valid, bus1.select, bus1.ack}; want = {1'b1, 4'd3, 16'h0008};
        n_cmp++; if (got !== want) begin n_bad++; $display("FAIL wrap_grant3: got %h want %h", got, want); end
        bus1.req = 16'h0000;
        @(negedge clk);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b0;
        bus4.req = '0; bus4.data = '0; bus4.out_ready = 1'b0;
        bus1.req = '0; bus1.data = '0; bus1.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        test_reset();
        test_burst_limit();
        test_backpressure();
        test_abort();
        test_round_robin();
        test_wrap_around();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
